// File: rtl/osd_vram_rx_if.sv
// OSD VRAM receive-side bus: CPU write vector in, display read port and status out.
interface osd_vram_rx_if;
  // OSDWrVector is level-based: no valid/ready; a command is taken once the vector
  // has sat unchanged long enough after a 00. rd_en is a one-cycle strobe with
  // rd_data returned on the next VCLK edge and held while rd_en is low.
  logic [24:0] OSDWrVector;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [12:0] rd_data;
  logic        busy;
  logic [7:0]  wr_cnt;
  logic [1:0]  state_dbg;

  modport master (output OSDWrVector, rd_en, rd_addr,
                  input  rd_data, busy, wr_cnt, state_dbg);
  modport slave  (input  OSDWrVector, rd_en, rd_addr,
                  output rd_data, busy, wr_cnt, state_dbg);
endinterface

// File: rtl/osd_vram_rx.sv
// VCLK-side OSD VRAM: synchronizes the CPU write vector, debounces it, and commits writes.
// Optional clear-all sweep (wrctrl=11) is built only when OSD_VRAM_CLEAR_ALL_EN is defined.
module osd_vram_rx #(
  parameter logic [12:0] clr_fill   = 13'h0000,
  parameter int unsigned stable_cyc = 2
) (
  input  logic         VCLK,
  input  logic         nVRST,
  osd_vram_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WR1 = 2'd1, WR2 = 2'd2, CLEAR = 2'd3} state_t;

  localparam logic [2:0] STAB_MAX = 3'(stable_cyc);

  logic [24:0] sync1, sync2, prev;
  logic [2:0]  stab_cnt;
  logic        vec_eq, stable, armed;
  logic [1:0]  s_ctrl;
  logic [9:0]  s_addr;
  logic [12:0] s_data;
  logic        cmd_wr, cmd_clr, idle_ctrl, accept, clr_last;
  state_t      state, state_nxt;
  logic [9:0]  wr_addr_q;
  logic [12:0] wr_data_q;
  logic        two_q;
  logic        we, busy_c;
  logic [9:0]  waddr;
  logic [12:0] wdata;
  logic [7:0]  wr_cnt_q;
  logic [12:0] rd_data_q;
  logic [12:0] mem [1024];

  // prev holds last cycle's synced vector; stab_cnt counts earlier cycles it matched
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stab_cnt <= '0;
    end else begin
      sync1 <= bus.OSDWrVector;
      sync2 <= sync1;
      prev  <= sync2;
      if (!vec_eq)                stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 3'd1;
    end
  end

  assign vec_eq = (sync2 == prev);
  assign stable = vec_eq && (({1'b0, stab_cnt} + 4'd1) >= 4'(stable_cyc));
  assign {s_ctrl, s_addr, s_data} = sync2;

`ifdef OSD_VRAM_CLEAR_ALL_EN
  logic [9:0] clr_addr;

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST)              clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 10'd1;
  end

  assign cmd_clr  = (s_ctrl == 2'b11);
  assign clr_last = (clr_addr == 10'd1023);
`else
  assign cmd_clr  = 1'b0;
  assign clr_last = 1'b1;
`endif

  assign cmd_wr    = (s_ctrl == 2'b01) || (s_ctrl == 2'b10);
  assign idle_ctrl = !cmd_wr && !cmd_clr;
  assign accept    = (state == IDLE) && stable && armed && (cmd_wr || cmd_clr);

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      state    <= IDLE;
      armed    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (accept)                  armed <= 1'b0;
        else if (stable && idle_ctrl) armed <= 1'b1;
      end
      if (accept && cmd_wr) wr_cnt_q <= wr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge VCLK) begin
    if (accept) begin
      wr_addr_q <= s_addr;
      wr_data_q <= s_data;
      two_q     <= (s_ctrl == 2'b10);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = cmd_clr ? CLEAR : WR1;
      WR1:     state_nxt = two_q ? WR2 : IDLE;
      WR2:     state_nxt = IDLE;
      CLEAR:   state_nxt = clr_last ? IDLE : CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we     = 1'b0;
    busy_c = 1'b0;
    waddr  = wr_addr_q;
    wdata  = wr_data_q;
    case (state)
      WR1: we = 1'b1;
      WR2: begin
        we    = 1'b1;
        waddr = wr_addr_q + 10'd1;
      end
`ifdef OSD_VRAM_CLEAR_ALL_EN
      CLEAR: begin
        we     = 1'b1;
        busy_c = 1'b1;
        waddr  = clr_addr;
        wdata  = clr_fill;
      end
`endif
      default: ;
    endcase
  end

  // Read register sees the pre-write word when both ports hit one address.
  always_ff @(posedge VCLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST)         rd_data_q <= '0;
    else if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy_c;
  assign bus.wr_cnt    = wr_cnt_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_osd_vram_rx.sv
// Self-checking bench for osd_vram_rx: random commands against a word-array model of the VRAM.
// Define OSD_VRAM_CLEAR_ALL_EN for both bench and RTL to exercise the clear-all sweep.
module tb_osd_vram_rx;
  localparam logic [12:0] CLR_FILL = 13'h0000;

  logic VCLK  = 1'b0;
  logic nVRST = 1'b0;

  osd_vram_rx_if bus ();

  osd_vram_rx #(.clr_fill(CLR_FILL), .stable_cyc(2)) dut (
    .VCLK  (VCLK),
    .nVRST (nVRST),
    .bus   (bus)
  );

  always #5 VCLK = ~VCLK;

  int          checks   = 0;
  int          failures = 0;
  logic [12:0] ref_mem [1024];
  bit          known   [1024];
  int          model_cnt = 0;
  logic [12:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic void model_apply(logic [1:0] c, logic [9:0] a, logic [12:0] d);
    logic [9:0] a1;
    a1 = a + 10'd1;
    if (c == 2'b01 || c == 2'b10) begin
      ref_mem[a] = d;
      known[a]   = 1'b1;
      model_cnt++;
      if (c == 2'b10) begin
        ref_mem[a1] = d;
        known[a1]   = 1'b1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_vec(logic [1:0] c, logic [9:0] a, logic [12:0] d, int hold);
    @(negedge VCLK);
    bus.OSDWrVector = {c, a, d};
    repeat (hold - 1) @(negedge VCLK);
  endtask

  task automatic send_cmd(logic [1:0] c, logic [9:0] a, logic [12:0] d);
    drive_vec(2'b00, 10'h000, 13'h0000, 8);
    drive_vec(c, a, d, 12);
    model_apply(c, a, d);
  endtask

  task automatic read_word(input logic [9:0] a, output logic [12:0] d);
    @(negedge VCLK);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    @(negedge VCLK);
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nVRST = 1'b0;
    repeat (3) @(negedge VCLK);
    checks++;
    if (bus.rd_data !== 13'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.wr_cnt !== 8'h0) begin failures++; $display("FAIL reset_wr_cnt got=%h exp=0", bus.wr_cnt); end
    nVRST = 1'b1;
    repeat (2) @(negedge VCLK);
  endtask

  task automatic test_single_write();
    logic [12:0] d;
    send_cmd(2'b01, 10'h005, 13'h1ABC);
    read_word(10'h005, d);
    checks++;
    if (d !== 13'h1ABC) begin failures++; $display("FAIL single_data got=%h exp=1abc", d); end
    checks++;
    if (bus.wr_cnt !== 8'd1) begin failures++; $display("FAIL single_wr_cnt got=%0d exp=1", bus.wr_cnt); end
  endtask

  task automatic test_double_write();
    logic [12:0] d;
    send_cmd(2'b10, 10'h3FF, 13'h0123);
    read_word(10'h3FF, d);
    checks++;
    if (d !== 13'h0123) begin failures++; $display("FAIL double_hi got=%h exp=0123", d); end
    read_word(10'h000, d);
    checks++;
    if (d !== 13'h0123) begin failures++; $display("FAIL double_wrap got=%h exp=0123", d); end
    checks++;
    if (bus.wr_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL double_wr_cnt got=%0d exp=%0d", bus.wr_cnt, 8'(model_cnt)); end
  endtask

  task automatic test_read_hold();
    logic [12:0] d;
    read_word(10'h005, d);
    @(negedge VCLK);
    bus.rd_addr = 10'h3FF;
    repeat (4) @(negedge VCLK);
    checks++;
    if (bus.rd_data !== ref_mem[5]) begin failures++; $display("FAIL read_hold got=%h exp=%h", bus.rd_data, ref_mem[5]); end
  endtask

  task automatic test_read_before_write();
    logic [7:0]  cs [40];
    logic [12:0] rs [40];
    logic [7:0]  cnt0;
    logic [12:0] old_d, new_d;
    int          k;
    old_d = ref_mem[5];
    new_d = ~old_d;
    cnt0  = bus.wr_cnt;
    @(negedge VCLK);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 10'h005;
    drive_vec(2'b00, 10'h000, 13'h0000, 8);
    @(negedge VCLK);
    bus.OSDWrVector = {2'b01, 10'h005, new_d};
    for (int i = 0; i < 40; i++) begin
      cs[i] = bus.wr_cnt;
      rs[i] = bus.rd_data;
      @(negedge VCLK);
    end
    bus.rd_en = 1'b0;
    model_apply(2'b01, 10'h005, new_d);
    k = -1;
    for (int i = 39; i >= 0; i--) if (cs[i] !== cnt0) k = i;
    checks++;
    if (k < 0 || k > 37) begin
      failures++;
      $display("FAIL rbw_accept_timeout k=%0d exp=0..37", k);
    end else begin
      checks++;
      if (rs[k+1] !== old_d) begin failures++; $display("FAIL rbw_same_cycle got=%h exp=%h", rs[k+1], old_d); end
      checks++;
      if (rs[k+2] !== new_d) begin failures++; $display("FAIL rbw_next_read got=%h exp=%h", rs[k+2], new_d); end
    end
  endtask

  task automatic test_unstable();
    logic [24:0] va, vb;
    logic [12:0] d;
    va = {2'b01, 10'h005, 13'($urandom_range(0, 8191))};
    vb = {2'b10, 10'h3FF, 13'($urandom_range(0, 8191))};
    drive_vec(2'b00, 10'h000, 13'h0000, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge VCLK);
      bus.OSDWrVector = (i % 2 == 0) ? va : vb;
    end
    drive_vec(2'b00, 10'h000, 13'h0000, 12);
    checks++;
    if (bus.wr_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL unstable_wr_cnt got=%0d exp=%0d", bus.wr_cnt, 8'(model_cnt)); end
    read_word(10'h005, d);
    checks++;
    if (d !== ref_mem[5]) begin failures++; $display("FAIL unstable_a got=%h exp=%h", d, ref_mem[5]); end
    read_word(10'h3FF, d);
    checks++;
    if (d !== ref_mem[1023]) begin failures++; $display("FAIL unstable_b got=%h exp=%h", d, ref_mem[1023]); end
  endtask

  task automatic test_held_command();
    logic [12:0] d1, d2, d3, d;
    d1 = 13'h0A5A;
    d2 = 13'h15A5;
    d3 = 13'h0777;
    drive_vec(2'b00, 10'h000, 13'h0000, 8);
    drive_vec(2'b01, 10'h040, d1, 100);
    model_apply(2'b01, 10'h040, d1);
    drive_vec(2'b01, 10'h040, d2, 20);
    checks++;
    if (bus.wr_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL held_wr_cnt got=%0d exp=%0d", bus.wr_cnt, 8'(model_cnt)); end
    read_word(10'h040, d);
    checks++;
    if (d !== d1) begin failures++; $display("FAIL held_one_write got=%h exp=%h", d, d1); end
    send_cmd(2'b01, 10'h040, d3);
    read_word(10'h040, d);
    checks++;
    if (d !== d3) begin failures++; $display("FAIL held_rearm got=%h exp=%h", d, d3); end
    checks++;
    if (bus.wr_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL held_rearm_cnt got=%0d exp=%0d", bus.wr_cnt, 8'(model_cnt)); end
  endtask

  task automatic test_random();
    logic [9:0]  addrs[$];
    logic [9:0]  a;
    logic [12:0] d, got;
    for (int i = 0; i < 24; i++) begin
      a = 10'($urandom_range(0, 1023));
      d = 13'($urandom_range(0, 8191));
      send_cmd(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, a, d);
      addrs.push_back(a);
      addrs.push_back(a + 10'd1);
    end
    for (int i = 0; i < 16; i++) begin
      a = addrs[$urandom_range(0, addrs.size() - 1)];
      if (known[a]) begin
        exp_q.push_back(ref_mem[a]);
        read_word(a, got);
        checks++;
        if (got !== exp_q[0]) begin failures++; $display("FAIL random_read addr=%h got=%h exp=%h", a, got, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    checks++;
    if (bus.wr_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL random_wr_cnt got=%0d exp=%0d", bus.wr_cnt, 8'(model_cnt)); end
  endtask

  task automatic test_wrap();
    while (model_cnt % 256 != 255)
      send_cmd(2'b01, 10'($urandom_range(0, 1023)), 13'($urandom_range(0, 8191)));
    checks++;
    if (bus.wr_cnt !== 8'hFF) begin failures++; $display("FAIL wrap_ff got=%h exp=ff", bus.wr_cnt); end
    send_cmd(2'b10, 10'($urandom_range(0, 1023)), 13'($urandom_range(0, 8191)));
    checks++;
    if (bus.wr_cnt !== 8'h00) begin failures++; $display("FAIL wrap_00 got=%h exp=00", bus.wr_cnt); end
    send_cmd(2'b01, 10'($urandom_range(0, 1023)), 13'($urandom_range(0, 8191)));
    checks++;
    if (bus.wr_cnt !== 8'h01) begin failures++; $display("FAIL wrap_01 got=%h exp=01", bus.wr_cnt); end
  endtask

`ifdef OSD_VRAM_CLEAR_ALL_EN
  task automatic test_clear_all();
    int          busy_cyc, bad;
    logic [12:0] d, dn;
    busy_cyc = 0;
    dn       = 13'h1357;
    drive_vec(2'b00, 10'h000, 13'h0000, 8);
    @(negedge VCLK);
    bus.OSDWrVector = {2'b11, 10'h000, 13'h0000};
    for (int i = 0; i < 1200; i++) begin
      if (i == 300) bus.OSDWrVector = '0;
      if (i == 320) bus.OSDWrVector = {2'b01, 10'h007, dn};
      @(negedge VCLK);
      if (bus.busy === 1'b1) busy_cyc++;
    end
    repeat (30) @(negedge VCLK);
    for (int i = 0; i < 1024; i++) begin ref_mem[i] = CLR_FILL; known[i] = 1'b1; end
    checks++;
    if (busy_cyc != 1024) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=1024", busy_cyc); end
    checks++;
    if (bus.wr_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL clear_ignored_cnt got=%0d exp=%0d", bus.wr_cnt, 8'(model_cnt)); end
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      read_word(10'(i), d);
      if (d !== CLR_FILL) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL clear_readback bad_words=%0d exp=0", bad); end
    send_cmd(2'b01, 10'h007, dn);
    read_word(10'h007, d);
    checks++;
    if (d !== dn) begin failures++; $display("FAIL clear_after_rearm got=%h exp=%h", d, dn); end
  endtask

  task automatic test_reset_mid_clear();
    logic [9:0]  pts [5];
    logic [12:0] d;
    int          t;
    pts = '{10'd100, 10'd511, 10'd512, 10'd700, 10'd1023};
    foreach (pts[i]) send_cmd(2'b01, pts[i], 13'($urandom_range(1, 8191)));
    drive_vec(2'b00, 10'h000, 13'h0000, 8);
    @(negedge VCLK);
    bus.OSDWrVector = {2'b11, 10'h000, 13'h0000};
    t = 0;
    while (bus.busy !== 1'b1 && t < 40) begin @(negedge VCLK); t++; end
    checks++;
    if (t >= 40) begin
      failures++;
      $display("FAIL midclr_busy_timeout waited=%0d exp<40", t);
    end else begin
      repeat (512) @(negedge VCLK);
      nVRST = 1'b0;
      bus.OSDWrVector = '0;
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL midclr_busy got=%b exp=0", bus.busy); end
      checks++;
      if (bus.wr_cnt !== 8'h0) begin failures++; $display("FAIL midclr_wr_cnt got=%h exp=0", bus.wr_cnt); end
      for (int i = 0; i < 512; i++) ref_mem[i] = CLR_FILL;
      model_cnt = 0;
      repeat (2) @(negedge VCLK);
      nVRST = 1'b1;
      repeat (2) @(negedge VCLK);
      foreach (pts[i]) begin
        read_word(pts[i], d);
        checks++;
        if (d !== ref_mem[pts[i]]) begin failures++; $display("FAIL midclr_keep addr=%0d got=%h exp=%h", pts[i], d, ref_mem[pts[i]]); end
      end
    end
  endtask
`else
  task automatic test_ctrl11_idle();
    int          busy_seen;
    logic [12:0] d, da, db;
    busy_seen = 0;
    da = 13'h0C3C;
    db = 13'h1E1E;
    drive_vec(2'b00, 10'h000, 13'h0000, 8);
    @(negedge VCLK);
    bus.OSDWrVector = {2'b11, 10'h000, 13'h0000};
    repeat (20) begin
      @(negedge VCLK);
      if (bus.busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin failures++; $display("FAIL ctrl11_busy cycles=%0d exp=0", busy_seen); end
    checks++;
    if (bus.wr_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL ctrl11_wr_cnt got=%0d exp=%0d", bus.wr_cnt, 8'(model_cnt)); end
    read_word(10'h3FF, d);
    checks++;
    if (d !== ref_mem[1023]) begin failures++; $display("FAIL ctrl11_ram got=%h exp=%h", d, ref_mem[1023]); end
    drive_vec(2'b00, 10'h000, 13'h0000, 8);
    drive_vec(2'b01, 10'h050, da, 12);
    model_apply(2'b01, 10'h050, da);
    drive_vec(2'b11, 10'h000, 13'h0000, 12);
    drive_vec(2'b01, 10'h051, db, 12);
    model_apply(2'b01, 10'h051, db);
    read_word(10'h051, d);
    checks++;
    if (d !== db) begin failures++; $display("FAIL ctrl11_rearm got=%h exp=%h", d, db); end
    checks++;
    if (bus.wr_cnt !== 8'(model_cnt)) begin failures++; $display("FAIL ctrl11_rearm_cnt got=%0d exp=%0d", bus.wr_cnt, 8'(model_cnt)); end
  endtask

  task automatic test_reset_mid();
    logic [12:0] d;
    int          n;
    drive_vec(2'b00, 10'h000, 13'h0000, 4);
    nVRST = 1'b0;
    #1;
    checks++;
    if (bus.wr_cnt !== 8'h0) begin failures++; $display("FAIL rst_mid_wr_cnt got=%h exp=0", bus.wr_cnt); end
    checks++;
    if (bus.rd_data !== 13'h0) begin failures++; $display("FAIL rst_mid_rd_data got=%h exp=0", bus.rd_data); end
    model_cnt = 0;
    repeat (3) @(negedge VCLK);
    nVRST = 1'b1;
    repeat (2) @(negedge VCLK);
    n = 0;
    for (int i = 0; i < 1024 && n < 8; i += 7) begin
      if (known[i]) begin
        read_word(10'(i), d);
        checks++;
        if (d !== ref_mem[i]) begin failures++; $display("FAIL rst_mid_keep addr=%0d got=%h exp=%h", i, d, ref_mem[i]); end
        n++;
      end
    end
    send_cmd(2'b01, 10'h123, 13'h0BEE);
    checks++;
    if (bus.wr_cnt !== 8'd1) begin failures++; $display("FAIL rst_mid_first_cmd got=%0d exp=1", bus.wr_cnt); end
  endtask
`endif

  initial begin
    bus.OSDWrVector = '0;
    bus.rd_en       = 1'b0;
    bus.rd_addr     = '0;
    foreach (known[i]) known[i] = 1'b0;
    test_reset();
    test_single_write();
    test_double_write();
    test_read_hold();
    test_read_before_write();
    test_unstable();
    test_held_command();
    test_random();
    test_wrap();
`ifdef OSD_VRAM_CLEAR_ALL_EN
    test_clear_all();
    test_reset_mid_clear();
`else
    test_ctrl11_idle();
    test_reset_mid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
